// File: rtl/usb_tx_line_driver.sv
// Full-speed USB serial line stage: NRZI encoding, optional bit stuffing, EOP generation.
// Define USB_TX_BITSTUFF_EN to enable in-line bit stuffing with upstream hold.
module usb_tx_line_driver #(
  parameter int EOP_SE0_BITS = 2,
  parameter int EOP_J_BITS   = 1
) (
  input  logic useClk,
  input  logic reset,
  input  logic checkData,
  input  logic txEnable,
  input  logic txBit,
  input  logic txEop,
  output logic txHold,
  output logic dPlus,
  output logic dMinus,
  output logic usbOE,
  output logic txBusy,
  output logic eopDone
);

  typedef enum logic [1:0] {IDLE, DATA, EOP_SE0, EOP_J} state_t;

  state_t     state;
  logic [7:0] eopCnt;
  logic       needRelease;  // txEnable must be seen low before the next packet
`ifdef USB_TX_BITSTUFF_EN
  logic [2:0] ones;
  logic       eopPend;
`else
  assign txHold = 1'b0;
`endif

  assign txBusy = (state != IDLE);

  always_ff @(posedge useClk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      eopCnt      <= '0;
      needRelease <= 1'b0;
      dPlus       <= 1'b1;
      dMinus      <= 1'b0;
      usbOE       <= 1'b0;
      eopDone     <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
      ones        <= '0;
      eopPend     <= 1'b0;
      txHold      <= 1'b0;
`endif
    end else begin
      eopDone <= 1'b0;
      if (checkData) begin
        case (state)
          IDLE: begin
            dPlus  <= 1'b1;
            dMinus <= 1'b0;
            usbOE  <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
            ones   <= '0;
`endif
            if (!txEnable) begin
              needRelease <= 1'b0;
            end else if (!needRelease) begin
              // First bit is encoded relative to J: 1 keeps J, 0 goes to K.
              state  <= DATA;
              usbOE  <= 1'b1;
              dPlus  <= txBit;
              dMinus <= ~txBit;
`ifdef USB_TX_BITSTUFF_EN
              ones   <= {2'b00, txBit};
`endif
            end
          end

          DATA: begin
`ifdef USB_TX_BITSTUFF_EN
            if (eopPend || (txEop && !txHold)) begin
              dPlus   <= 1'b0;
              dMinus  <= 1'b0;
              state   <= EOP_SE0;
              eopCnt  <= 8'd1;
              eopPend <= 1'b0;
            end else if (txEop) begin
              // Stuff bit goes out first; EOP follows on the next strobe.
              dPlus   <= ~dPlus;
              dMinus  <= ~dMinus;
              txHold  <= 1'b0;
              ones    <= '0;
              eopPend <= 1'b1;
            end else if (!txEnable) begin
              dPlus  <= 1'b1;
              dMinus <= 1'b0;
              usbOE  <= 1'b0;
              txHold <= 1'b0;
              ones   <= '0;
              state  <= IDLE;
            end else if (txHold) begin
              dPlus  <= ~dPlus;
              dMinus <= ~dMinus;
              txHold <= 1'b0;
              ones   <= '0;
            end else if (txBit) begin
              if (ones == 3'd5) txHold <= 1'b1;
              ones <= ones + 3'd1;
            end else begin
              dPlus  <= ~dPlus;
              dMinus <= ~dMinus;
              ones   <= '0;
            end
`else
            if (txEop) begin
              dPlus  <= 1'b0;
              dMinus <= 1'b0;
              state  <= EOP_SE0;
              eopCnt <= 8'd1;
            end else if (!txEnable) begin
              dPlus  <= 1'b1;
              dMinus <= 1'b0;
              usbOE  <= 1'b0;
              state  <= IDLE;
            end else if (!txBit) begin
              dPlus  <= ~dPlus;
              dMinus <= ~dMinus;
            end
`endif
          end

          EOP_SE0: begin
            if (eopCnt >= 8'(EOP_SE0_BITS)) begin
              dPlus  <= 1'b1;
              dMinus <= 1'b0;
              state  <= EOP_J;
              eopCnt <= 8'd1;
            end else begin
              eopCnt <= eopCnt + 8'd1;
            end
          end

          EOP_J: begin
            if (eopCnt >= 8'(EOP_J_BITS)) begin
              usbOE       <= 1'b0;
              eopDone     <= 1'b1;
              state       <= IDLE;
              eopCnt      <= '0;
              needRelease <= txEnable;
            end else begin
              eopCnt <= eopCnt + 8'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/usb_tx_line_driver.md
# usb_tx_line_driver

Serial line stage downstream of the descriptor transmitter: takes its raw NRZ bit stream (`txBit`, `txEnable`, `txEop`) at one bit per `checkData` strobe and produces the full-speed USB line levels. Performs NRZI encoding, optional bit stuffing with upstream hold, and EOP generation (SE0 then J). It also drives the transceiver output enable `usbOE`. It sits between the packet/descriptor transmitters and the D+/D- pad drivers.

## Interface
- `EOP_SE0_BITS`, default 2: bit times of SE0 in EOP.
- `EOP_J_BITS`, default 1: bit times of J after SE0 before release.
- `useClk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high reset.
- `checkData` in 1: bit-time strobe, one `useClk` pulse per 12 Mb/s bit; all state advances only on `useClk` edges with `checkData`=1.
- `txEnable` in 1: upstream transmit enable; high for the whole packet.
- `txBit` in 1: raw NRZ bit (SYNC, PID, data, CRC), LSB-first as supplied by upstream.
- `txEop` in 1: request EOP. Sampled like `txBit`; the bit on `txBit` in that strobe is not sent.
- `txHold` out 1: registered; 1 = stuff bit pending, upstream must not advance at the next strobe.
- `dPlus`, `dMinus` out 1 each: registered line levels.
- `usbOE` out 1: registered transceiver drive enable.
- `txBusy` out 1: high in any state except IDLE.
- `eopDone` out 1: one-`useClk` pulse when the final J bit completes.

## Operation
- States: IDLE, DATA, EOP_SE0, EOP_J.
- Line symbols: J = (`dPlus`=1, `dMinus`=0), K = (0,1), SE0 = (0,0).
- IDLE:
  - Line held at J, `usbOE`=0, ones counter cleared.
  - On a strobe with `txEnable`=1, go to DATA, set `usbOE`=1, and encode `txBit` of that same strobe.
- DATA, NRZI encoding:
  - Bit 0 toggles J/K; bit 1 holds the line.
  - Encoding is relative to the previous line symbol; the first bit is relative to J.
- DATA, stuffing:
  - A 3-bit ones counter counts consecutive transmitted 1s and clears on any transmitted 0, stuffed or real.
  - On the edge that transmits the 6th consecutive 1, set `txHold`=1.
  - At the next strobe, emit a stuffed 0 (toggle), ignore `txBit`, clear `txHold` and the counter.
- DATA, EOP and abort:
  - `txEop`=1 at a strobe enters EOP_SE0 and drives SE0.
  - If `txHold`=1 at that strobe, emit the stuff bit first, latch the EOP request, and enter EOP_SE0 at the following strobe. The bit is never dropped.
  - `txEnable`=0 at a strobe without `txEop` aborts: J, `usbOE`=0, IDLE, no `eopDone`.
- EOP_SE0: SE0 for `EOP_SE0_BITS` strobes, then EOP_J.
- EOP_J:
  - J for `EOP_J_BITS` strobes.
  - On the last one, `usbOE`=0, `eopDone`=1 for that `useClk` cycle, then IDLE.
- Inputs are ignored in EOP states. `txEnable` still high after EOP must drop to 0 before a new packet starts; a re-armed rising level is required.

## Timing
- Reset values: `dPlus`=1, `dMinus`=0, `usbOE`=0, `txHold`=0, `txBusy`=0, `eopDone`=0, state IDLE, counters 0.
- Reset is asynchronous: asserting mid-packet forces the reset values immediately, with no EOP emitted.
- Latency: the bit sampled at strobe n appears on the line from the `useClk` edge of strobe n and holds until strobe n+1.
- `txHold` rises on the same edge as the 6th 1 and falls on the edge of the next strobe.
- Packet length on the wire = data bits + stuff bits + `EOP_SE0_BITS` + `EOP_J_BITS` strobes.
- Strobes arriving on consecutive `useClk` cycles are legal.

## Configuration
- `USB_TX_BITSTUFF_EN` defined: stuffing as above.
- `USB_TX_BITSTUFF_EN` not defined:
  - No stuffing; upstream is responsible for stuffing.
  - `txHold` is tied 0 and the ones counter is removed.
  - Every strobe in DATA consumes `txBit`.
  - `txEop` always enters EOP_SE0 immediately.

## Test plan
- Reset pulse mid-DATA → within the same cycle `dPlus`=1, `dMinus`=0, `usbOE`=0, `txBusy`=0.
- SYNC `txBit` 0,0,0,0,0,0,0,1 from IDLE → line K,J,K,J,K,J,K,K with `usbOE`=1 from the first strobe.
- Eight 1s after a 0 (macro on) → line static for 6 bits; `txHold`=1 for exactly one strobe; toggle; static for 2 more bits; total 9 strobes.
- `txEop` at a strobe while `txHold`=1 → stuffed toggle, then SE0, SE0, J; `eopDone` one cycle; `usbOE`=0 afterwards.
- `txEnable` dropped mid-packet without `txEop` → J, `usbOE`=0 on that strobe, no `eopDone`, `txBusy`=0.
- Macro off, eight 1s → no toggle for 8 strobes; `txHold` stays 0.
